// File: rtl/addsub_sched_if.sv
// Request/grant and result bundle for the shared serial add/subtract unit.
// The requesters drive the master side; addsub_sched takes the slave side.
interface addsub_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         m0;
  logic         m1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output req0, req1, a0, b0, a1, b1, m0, m1,
    input  gnt0, gnt1, busy, done, done_id, result, cout, ovf
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, m0, m1,
    output gnt0, gnt1, busy, done, done_id, result, cout, ovf
  );
endinterface

// File: rtl/addsub_sched.sv
// Two-requester round-robin scheduler around one 4-bit add/subtract slice,
// reused serially LSB nibble first to build a 4*NIBBLES-bit sum or difference.
module addsub_sched #(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  addsub_sched_if.slave bus
);
  localparam int DATA_W = 4 * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               rr;
  logic               rr_nxt;
  logic               capture;
  logic               win;
  logic               last;

  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic                     mode_p0;
  logic                     id_p0;
  logic signed [DATA_W-1:0] acc_p1;
  logic                     carry_p1;

  logic [IDX_W+1:0]         base;
  logic                     cin;
  logic [4:0]               sum;
  logic signed [DATA_W-1:0] res_word;
  logic signed [DATA_W-1:0] b_eff;

  logic                     gnt0_q;
  logic                     gnt1_q;
  logic                     done_id_q;
  logic signed [DATA_W-1:0] result_q;
  logic                     cout_q;
  logic                     ovf_q;

  function automatic logic [4:0] slice_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic m, input logic c);
    return {1'b0, a} + {1'b0, b ^ {4{m}}} + {4'b0000, c};
  endfunction

  function automatic logic ovf_calc(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rr    <= rr_nxt;
    end
  end

  // Arbitration only ever happens in IDLE; the pointer flips to the loser.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rr_nxt    = rr;
    capture   = 1'b0;
    win       = rr;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          capture   = 1'b1;
          win       = (bus.req0 && bus.req1) ? rr : bus.req1;
          rr_nxt    = ~win;
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (idx == IDX_W'(NIBBLES - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk) begin
    if (capture) begin
      op_a_p0 <= win ? bus.a1 : bus.a0;
      op_b_p0 <= win ? bus.b1 : bus.b0;
      mode_p0 <= win ? bus.m1 : bus.m0;
      id_p0   <= win;
    end
  end

  always_comb begin
    base     = {idx, 2'b00};
    cin      = (idx == '0) ? mode_p0 : carry_p1;
    sum      = slice_add(op_a_p0[base +: 4], op_b_p0[base +: 4], mode_p0, cin);
    res_word = acc_p1;
    res_word[base +: 4] = sum[3:0];
    b_eff    = op_b_p0 ^ {DATA_W{mode_p0}};
  end

  // ---- stage p1: serial nibble accumulation ----
  always_ff @(posedge clk) begin
    if (state == RUN) begin
      acc_p1   <= res_word;
      carry_p1 <= sum[4];
    end
  end

  // ---- stage p2: presented result, held until the next completion ----
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      gnt0_q <= capture && !win;
      gnt1_q <= capture && win;
      if (last) begin
        done_id_q <= id_p0;
        result_q  <= res_word;
        cout_q    <= sum[4];
        ovf_q     <= ovf_calc(op_a_p0, b_eff, res_word);
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched: arithmetic vectors, arbitration order,
// grant spacing and abort on reset; inputs change and outputs sample on negedge.
module tb_addsub_sched;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  addsub_sched_if #(.NIBBLES(4)) bus ();
  addsub_sched #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input bit id, input logic [15:0] a, input logic [15:0] b,
                    input bit m, input logic [15:0] er, input bit ec, input bit eo);
    if (id) begin bus.req1 = 1; bus.a1 = a; bus.b1 = b; bus.m1 = m; end
    else    begin bus.req0 = 1; bus.a0 = a; bus.b0 = b; bus.m0 = m; end
    @(negedge clk);
    chk({tag, ".gnt"}, id ? bus.gnt1 : bus.gnt0, 1);
    chk({tag, ".gnt_other"}, id ? bus.gnt0 : bus.gnt1, 0);
    chk({tag, ".busy"}, bus.busy, 1);
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    chk({tag, ".gnt_pulse"}, {bus.gnt0, bus.gnt1}, 0);
    // scramble operands after the grant: captured values must be used
    bus.a0 = 16'hDEAD; bus.b0 = 16'hBEEF; bus.m0 = ~m;
    bus.a1 = 16'hCAFE; bus.b1 = 16'hF00D; bus.m1 = ~m;
    chk({tag, ".done_early"}, bus.done, 0);
    repeat (2) @(negedge clk);
    chk({tag, ".done_early2"}, bus.done, 0);
    @(negedge clk);
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".busy_done"}, bus.busy, 1);
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".cout"}, bus.cout, ec);
    chk({tag, ".ovf"}, bus.ovf, eo);
    chk({tag, ".done_id"}, bus.done_id, id);
    @(negedge clk);
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".busy_idle"}, bus.busy, 0);
    chk({tag, ".result_hold"}, bus.result, er);
  endtask

  initial begin
    int pos;
    int dcnt;
    rst = 1;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.m0 = 0;
    bus.a1 = 0; bus.b1 = 0; bus.m1 = 0;
    repeat (2) @(negedge clk);
    chk("rst.outs", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout, bus.ovf}, 0);
    chk("rst.result", bus.result, 0);
    rst = 0;
    @(negedge clk);

    op("add0", 0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0);
    op("sub1", 1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
    op("ovf_add", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    op("ovf_sub", 0, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);

    // arbitration from a fresh reset
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus.req0 = 1; bus.a0 = 16'h0001; bus.b0 = 16'h0002; bus.m0 = 0;
    bus.req1 = 1; bus.a1 = 16'h0010; bus.b1 = 16'h0003; bus.m1 = 0;
    @(negedge clk);
    chk("arb1.gnt0", bus.gnt0, 1);
    chk("arb1.gnt1", bus.gnt1, 0);
    bus.req0 = 0;
    pos = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.gnt1) begin pos = i; break; end
    end
    chk("arb1.spacing", pos, 6);
    bus.req1 = 0;
    repeat (4) @(negedge clk);
    chk("arb1.done", bus.done, 1);
    chk("arb1.done_id", bus.done_id, 1);
    chk("arb1.result", bus.result, 16'h0013);
    @(negedge clk);
    chk("arb1.idle", bus.busy, 0);

    bus.req0 = 1; bus.req1 = 1;
    @(negedge clk);
    chk("arb2.gnt0", bus.gnt0, 1);
    chk("arb2.gnt1", bus.gnt1, 0);
    bus.req0 = 0;
    pos = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.gnt1) begin pos = i; break; end
    end
    chk("arb2.spacing", pos, 6);
    bus.req1 = 0;
    repeat (5) @(negedge clk);
    chk("arb2.idle", bus.busy, 0);

    // reset in the second RUN cycle aborts the operation
    bus.req0 = 1; bus.a0 = 16'h1111; bus.b0 = 16'h2222; bus.m0 = 0;
    @(negedge clk);
    chk("abort.gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort.outs", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout, bus.ovf}, 0);
    chk("abort.result", bus.result, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort.no_done", dcnt, 0);
    op("post_rst", 0, 16'h0001, 16'h0001, 0, 16'h0002, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/addsub_sched.md
ADDSUB_SCHED -- requirements
Module: addsub_sched

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  W each  operands of requester 0 / 1.
REQ-006 m0, m1  input  1 each  mode of requester 0 / 1: 0 = add (a+b), 1 = subtract (a-b).
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands accepted.
REQ-008 busy  output  1  high while an operation is in progress, through its done cycle.
REQ-009 done  output  1  one-cycle pulse; result, cout, ovf and done_id are valid.
REQ-010 done_id  output  1  index of the requester whose result is presented.
REQ-011 result  output  W  sum/difference.
REQ-012 cout  output  1  final carry out; on subtract, 1 = no borrow (a >= b unsigned).
REQ-013 ovf  output  1  signed two's-complement overflow.

Function
REQ-014 One shared 4-bit add/subtract slice: s = a_nib + (b_nib XOR {4{m}}) + cin; the slice is reused serially, least significant nibble first.
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on capture; RUN->DONE after NIBBLES nibble cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 Arbitration occurs only in IDLE; no request is accepted in RUN or DONE.
REQ-017 In IDLE with exactly one req high, that requester wins; with both high, the requester named by the round-robin pointer wins.
REQ-018 After each capture, the pointer moves to the requester not served.
REQ-019 At the capture edge, the winner's a, b, m and id are registered, state becomes RUN, nibble index is 0, and the winner's gnt is high for the following cycle only.
REQ-020 Requester holds req, a, b and m stable until it samples its gnt high, then may deassert req; the operand registers are not affected by later input changes.
REQ-021 RUN, nibble index k: slice cin = m when k = 0, else the registered carry. At the edge, nibble k of result and the carry register are written.
REQ-022 Nibble index increments modulo NIBBLES; after index NIBBLES-1 is written, state becomes DONE.
REQ-023 Latency: done is high exactly NIBBLES cycles after the gnt cycle (gnt in cycle C0, done in cycle C0+NIBBLES).
REQ-024 busy is high from the gnt cycle through the done cycle inclusive, and low in IDLE.
REQ-025 In DONE: cout = final carry; ovf = (a[W-1] == b'[W-1]) AND (result[W-1] != a[W-1]), with b' = b XOR {W{m}}.
REQ-026 result, cout, ovf and done_id hold their values after done until the next done; intermediate nibble writes go to an internal register, not to result.
REQ-027 Minimum spacing between grants is NIBBLES+2 cycles; a request pending during RUN/DONE is granted from the IDLE cycle following DONE.

Reset
REQ-028 rst high at an edge forces IDLE, pointer = 0, and gnt0, gnt1, busy, done, done_id, result, cout and ovf all = 0, overriding all other activity.
REQ-029 Reset during RUN or DONE aborts the operation; no done pulse follows for it.

Verification
REQ-030 req0, a0=0x1234, b0=0x0FFF, m0=0 -> gnt0 one cycle; done 4 cycles later; result=0x2233, cout=0, ovf=0, done_id=0.
REQ-031 req1, a1=0x0005, b1=0x0007, m1=1 -> result=0xFFFE, cout=0, ovf=0, done_id=1.
REQ-032 a0=0x7FFF, b0=0x0001, m0=0 -> result=0x8000, cout=0, ovf=1; then a0=0x8000, b0=0x0001, m0=1 -> result=0x7FFF, cout=1, ovf=1.
REQ-033 After reset, req0 and req1 raised in the same cycle and held until granted -> gnt0 first; gnt1 exactly 6 cycles after gnt0. A second simultaneous pair -> gnt0 first again.
REQ-034 rst asserted in the second RUN cycle -> next cycle all outputs 0, busy=0, and no done. A following req0 (0x0001+0x0001) -> result=0x0002 with normal latency.
REQ-035 Operands changed on the cycle after gnt -> result reflects the captured values.
